// File: rtl/cgol_pkg.sv
// Shared board geometry, row type and toroidal neighbour-index helpers for the
// Game-of-Life row store.
package cgol_pkg;

   localparam int unsigned ROWS  = 16;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned AW    = 4;

   typedef logic [WIDTH-1:0] row_t;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned rows);
      return (idx + 1 >= rows) ? 0 : idx + 1;
   endfunction

   function automatic int unsigned wrap_dec(input int unsigned idx, input int unsigned rows);
      return (idx == 0) ? rows - 1 : idx - 1;
   endfunction

endpackage

// File: rtl/current_state_if.sv
// Row-store access bus: a single write port plus a read port that returns the
// addressed row together with its upper and lower toroidal neighbours.
interface current_state_if #(
   parameter int unsigned WIDTH = cgol_pkg::WIDTH,
   parameter int unsigned AW    = cgol_pkg::AW
);
   logic             regwrite;
   logic [AW-1:0]    ra;
   logic [AW-1:0]    wa;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] rd;
   logic [WIDTH-1:0] rd_up;
   logic [WIDTH-1:0] rd_dn;

   modport master (output regwrite, ra, wa, wd, input rd, rd_up, rd_dn);
   modport slave  (input regwrite, ra, wa, wd, output rd, rd_up, rd_dn);
endinterface

// File: rtl/current_state.sv
// Current Game-of-Life generation: ROWS x WIDTH register file with one write
// port and a combinational three-row (up/centre/down) toroidal read port.
module current_state #(
   parameter int unsigned ROWS  = cgol_pkg::ROWS,
   parameter int unsigned WIDTH = cgol_pkg::WIDTH,
   parameter int unsigned AW    = cgol_pkg::AW
) (
   input  logic              ph1,
   input  logic              reset,
   current_state_if.slave    bus_io
);
   import cgol_pkg::*;

   logic [WIDTH-1:0] rows_q [ROWS];
   logic [WIDTH-1:0] rows_d [ROWS];

   int unsigned ra_idx;
   int unsigned wa_idx;
   int unsigned up_idx;
   int unsigned dn_idx;

   assign ra_idx = 32'(bus_io.ra);
   assign wa_idx = 32'(bus_io.wa);

   // Out-of-range write addresses match no row, so they are silently dropped.
   always_comb begin
      rows_d = rows_q;
      if (bus_io.regwrite) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            if (r == wa_idx) rows_d[r] = bus_io.wd;
         end
      end
   end

   always_ff @(posedge ph1) begin
      if (!reset) begin
         for (int unsigned r = 0; r < ROWS; r++) rows_q[r] <= '0;
      end else begin
         rows_q <= rows_d;
      end
   end

   // Reads come from registered state only, so a same-cycle write is not forwarded.
   always_comb begin
      up_idx       = wrap_dec(ra_idx, ROWS);
      dn_idx       = wrap_inc(ra_idx, ROWS);
      bus_io.rd    = '0;
      bus_io.rd_up = '0;
      bus_io.rd_dn = '0;
      if (ra_idx < ROWS) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            if (r == ra_idx) bus_io.rd    = rows_q[r];
            if (r == up_idx) bus_io.rd_up = rows_q[r];
            if (r == dn_idx) bus_io.rd_dn = rows_q[r];
         end
      end
   end

endmodule

// File: tb/tb_current_state.sv
// Self-checking bench for current_state: directed literal checks plus a random
// phase compared every cycle against an array model of the board.
module tb_current_state;
   import cgol_pkg::*;

   logic ph1;
   logic reset;
   int   checks;
   int   errors;
   bit   chk_en;
   row_t model [ROWS];

   current_state_if bus ();

   current_state dut (
      .ph1    (ph1),
      .reset  (reset),
      .bus_io (bus)
   );

   initial ph1 = 1'b0;
   always #5 ph1 = ~ph1;

   // Reference board: whole-row array updated from the rules at each rising edge.
   always @(posedge ph1) begin
      if (!reset) begin
         for (int i = 0; i < ROWS; i++) model[i] = '0;
      end else if (bus.regwrite) begin
         model[int'(bus.wa)] = bus.wd;
      end
   end

   task automatic check(input string name, input row_t act, input row_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare on the falling edge, away from state updates and stimulus.
   always @(negedge ph1) begin
      if (chk_en) begin
         int a;
         a = int'(bus.ra);
         check("cyc_rd",    bus.rd,    model[a]);
         check("cyc_rd_up", bus.rd_up, model[(a + ROWS - 1) % ROWS]);
         check("cyc_rd_dn", bus.rd_dn, model[(a + 1) % ROWS]);
      end
   end

   task automatic tick();
      @(posedge ph1);
      #2;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      chk_en       = 1'b0;
      reset        = 1'b0;
      bus.regwrite = 1'b0;
      bus.ra       = '0;
      bus.wa       = '0;
      bus.wd       = '0;
      tick();
      tick();
      reset  = 1'b1;
      chk_en = 1'b1;

      // Cleared board reads zero everywhere.
      for (int i = 0; i < ROWS; i++) begin
         bus.ra = AW'(i);
         #1;
         check("reset_rd",    bus.rd,    8'h00);
         check("reset_rd_up", bus.rd_up, 8'h00);
         check("reset_rd_dn", bus.rd_dn, 8'h00);
      end

      // Write row 5 and read it back with its neighbours.
      bus.regwrite = 1'b1; bus.wa = 4'd5; bus.wd = 8'hA5;
      tick();
      bus.regwrite = 1'b0; bus.ra = 4'd5;
      #1;
      check("wr_rd",    bus.rd,    8'hA5);
      check("wr_rd_up", bus.rd_up, 8'h00);
      check("wr_rd_dn", bus.rd_dn, 8'h00);

      // Toroidal wrap at ra=0.
      bus.regwrite = 1'b1; bus.wa = 4'd15; bus.wd = 8'h81;
      tick();
      bus.wa = 4'd1; bus.wd = 8'h3C;
      tick();
      bus.regwrite = 1'b0; bus.ra = 4'd0;
      #1;
      check("wrap_rd_up", bus.rd_up, 8'h81);
      check("wrap_rd_dn", bus.rd_dn, 8'h3C);
      check("wrap_rd",    bus.rd,    8'h00);
      bus.ra = 4'd15;
      #1;
      check("wrap15_rd_dn", bus.rd_dn, 8'h00);
      check("wrap15_rd",    bus.rd,    8'h81);

      // Disabled write leaves the row alone.
      bus.regwrite = 1'b0; bus.wa = 4'd5; bus.wd = 8'hFF;
      tick();
      bus.ra = 4'd5;
      #1;
      check("nowr_rd", bus.rd, 8'hA5);

      // Same-address collision: old value until the edge, new value after.
      bus.ra = 4'd7; bus.wa = 4'd7; bus.wd = 8'h0F; bus.regwrite = 1'b1;
      #1;
      check("coll_before", bus.rd, 8'h00);
      tick();
      bus.regwrite = 1'b0;
      #1;
      check("coll_after", bus.rd, 8'h0F);

      // Reset overrides a simultaneous write and clears earlier writes.
      reset = 1'b0; bus.regwrite = 1'b1; bus.wa = 4'd2; bus.wd = 8'hFF;
      tick();
      reset = 1'b1; bus.regwrite = 1'b0; bus.ra = 4'd2;
      #1;
      check("rstpri_rd", bus.rd, 8'h00);
      bus.ra = 4'd7;
      #1;
      check("rstpri_row7", bus.rd, 8'h00);
      bus.ra = 4'd0;
      #1;
      check("rstpri_row15", bus.rd_up, 8'h00);

      // Random traffic, checked each cycle by the compare process.
      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(0, 59) != 0);
         bus.regwrite = $urandom_range(0, 1) == 1;
         bus.ra       = AW'($urandom_range(0, ROWS - 1));
         bus.wa       = ($urandom_range(0, 3) == 0) ? bus.ra : AW'($urandom_range(0, ROWS - 1));
         bus.wd       = WIDTH'($urandom);
         tick();
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/current_state.md
CURRENT_STATE -- requirements
Module: current_state

Interface
REQ-001 Parameter ROWS, default 16: number of board rows stored.
REQ-002 Parameter WIDTH, default 8: cells per row, one bit per cell.
REQ-003 Parameter AW, default 4: address width, equal to clog2(ROWS).
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-005 ph1  input  1  the single clock; all state updates occur on its rising edge.
REQ-006 reset  input  1  synchronous, active-low; 0 clears the board.
REQ-007 regwrite  input  1  write enable for row wa.
REQ-008 ra  input  AW  read row address.
REQ-009 wa  input  AW  write row address; may equal ra.
REQ-010 wd  input  WIDTH  write data; bit i = cell i of row wa, 1 = alive.
REQ-011 rd  output  WIDTH  contents of row ra.
REQ-012 rd_up  output  WIDTH  contents of row (ra-1) mod ROWS.
REQ-013 rd_dn  output  WIDTH  contents of row (ra+1) mod ROWS.

Function
REQ-014 Storage SHALL be ROWS registers of WIDTH bits, the current Game-of-Life generation.
REQ-015 rd, rd_up and rd_dn SHALL be combinational from stored state and ra, with zero-cycle latency.
REQ-016 On the rising edge of ph1 with reset=1 and regwrite=1, row wa SHALL take wd; all other rows SHALL hold.
REQ-017 On the rising edge of ph1 with reset=1 and regwrite=0, all rows SHALL hold.
REQ-018 Same-cycle ra==wa write: outputs SHALL show the old row until the edge and the new row after it (no write-through).
REQ-019 Row wrap-around SHALL be toroidal:
- ra=0 gives rd_up = row ROWS-1.
- ra=ROWS-1 gives rd_dn = row 0.
REQ-020 Address arithmetic SHALL be modulo ROWS; when ROWS is not a power of two, addresses >= ROWS SHALL read as 0 and writes to them SHALL be ignored.
REQ-021 No bit reordering: wd[i] SHALL be stored as bit i and returned as rd[i].

Reset
REQ-022 On the rising edge of ph1 with reset=0, every row SHALL clear to 0, overriding regwrite.
REQ-023 After reset, rd, rd_up and rd_dn SHALL read 0 for every ra until a write occurs.
REQ-024 Reset asserted mid-sequence SHALL discard all prior writes in the same edge.
REQ-025 There SHALL be no asynchronous reset path.

Structure
REQ-026 Shared package cgol_pkg SHALL hold ROWS, WIDTH, AW and the typedef row_t (logic [WIDTH-1:0]).
REQ-027 The neighbour-index helper (wrap increment/decrement) SHALL be a function in cgol_pkg.
REQ-028 The design SHALL be a single flat module; no sub-module is required.

Verification
REQ-029 Reset:
- Stimulus: reset=0 for one edge, then ra=0..15.
- Response: rd=rd_up=rd_dn=8'h00 for every ra.
REQ-030 Write then read:
- Stimulus: regwrite=1, wa=5, wd=8'hA5, one edge, then ra=5.
- Response: rd=8'hA5, rd_up=row4=8'h00, rd_dn=row6=8'h00.
REQ-031 Wrap-around:
- Stimulus: write row15=8'h81 and row1=8'h3C, then ra=0.
- Response: rd_up=8'h81, rd_dn=8'h3C.
REQ-032 Write disabled:
- Stimulus: regwrite=0, wa=5, wd=8'hFF, one edge.
- Response: rd at ra=5 still 8'hA5.
REQ-033 Same-address collision:
- Stimulus: ra=wa=7, wd=8'h0F, regwrite=1.
- Response: rd=8'h00 before the edge and 8'h0F after it.
REQ-034 Reset priority:
- Stimulus: reset=0 and regwrite=1, wa=2, wd=8'hFF on the same edge.
- Response: row 2 reads 8'h00.
